// File: rtl/fetch_unit_pkg.sv
// fetch_pkg: types, constants and helpers shared by the fetch stage.
//   fetch_state_t : control FSM states (IDLE, RUN, HALT)
//   EBREAK_INSN   : instruction word that halts fetching
//   OPC_JAL       : JAL major opcode
//   PC_STEP       : sequential PC increment (bytes)
//   j_imm()       : sign-extended J-type immediate
// REG_RANGE normally comes from inst_defs.sv; the guarded fallback keeps
// this package self-contained regardless of file order.
`ifndef REG_RANGE
`define REG_RANGE 31:0
`endif

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [`REG_RANGE] EBREAK_INSN = 32'h0010_0073;
    localparam logic [6:0]        OPC_JAL     = 7'b110_1111;
    localparam logic [`REG_RANGE] PC_STEP     = 32'd4;

    // J-type immediate: imm[20|10:1|11|19:12] scattered over instr[31:12].
    function automatic logic [`REG_RANGE] j_imm(input logic [`REG_RANGE] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_if: bundle of all non-clock/reset signals of the fetch stage.
//   master : fetch_unit side (drives imem_addr and the IF/ID outputs)
//   slave  : environment side (memory, execute, decode, control)
// Parameters: WIDTH (instruction/PC width), ADDR_W (memory word-address width).
interface fetch_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [WIDTH-1:0]  imem_data;
    logic              redirect_valid;
    logic [WIDTH-1:0]  redirect_pc;
    logic              id_ready;
    logic              if_valid;
    logic [WIDTH-1:0]  if_instr;
    logic [WIDTH-1:0]  if_pc;
    logic              halted;
    logic              misaligned;
    logic [31:0]       fetch_count;

    modport master (
        input  start, imem_data, redirect_valid, redirect_pc, id_ready,
        output imem_addr, if_valid, if_instr, if_pc, halted, misaligned,
               fetch_count
    );

    modport slave (
        output start, imem_data, redirect_valid, redirect_pc, id_ready,
        input  imem_addr, if_valid, if_instr, if_pc, halted, misaligned,
               fetch_count
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC selection for the fetch stage.
//   pc_q         : current PC
//   redirect     : effective redirect this cycle (already gated by FSM state)
//   redirect_pc  : redirect target byte address
//   accept       : an instruction is captured this cycle
//   instr        : word being captured (used for JAL prediction)
//   pc_d         : next PC
//   misaligned_d : redirect target had nonzero low bits
// Optional feature macro: FETCH_JAL_PREDICT_EN (follow JAL targets at fetch).
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_q,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             accept,
    input  logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc_d,
    output logic             misaligned_d
);

    logic [WIDTH-1:0] step_pc;

`ifdef FETCH_JAL_PREDICT_EN
    always_comb begin
        step_pc = pc_q + PC_STEP;
        if (instr[6:0] == OPC_JAL) step_pc = pc_q + j_imm(instr);
    end
`else
    logic unused_instr;
    assign unused_instr = ^instr;
    assign step_pc      = pc_q + PC_STEP;
`endif

    // Redirect wins over everything; the target is forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (redirect)    pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
        else if (accept) pc_d = step_pc;
    end

    assign misaligned_d = redirect && (|redirect_pc[1:0]);

endmodule

// File: rtl/inst_defs.sv
// Shared instruction-field ranges.
//   REG_RANGE : bit range of an instruction word / architectural register.
`ifndef INST_DEFS_SV
`define INST_DEFS_SV
`define REG_RANGE 31:0
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a combinational-read imem.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : fetch_if.master (start, imem port, redirect, IF/ID handshake,
//           halted, misaligned pulse, fetch_count)
// Optional feature macro: FETCH_JAL_PREDICT_EN (see fetch_pc_gen).
`ifndef REG_RANGE
`define REG_RANGE 31:0
`endif

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          SIZE     = 256,
    parameter int          ADDR_W   = $clog2(SIZE),
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master bus
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             if_valid_q, if_valid_d;
    logic [WIDTH-1:0] if_instr_q, if_instr_d;
    logic [WIDTH-1:0] if_pc_q, if_pc_d;
    logic             misaligned_q, misaligned_d;
    logic [31:0]      fetch_count_q, fetch_count_d;

    logic redirect, accept, deliver;

    // Redirects are ignored until the first start has been seen.
    assign redirect = bus.redirect_valid && (state_q != IDLE);
    assign accept   = (state_q == RUN) && (!if_valid_q || bus.id_ready)
                      && !bus.redirect_valid;
    assign deliver  = if_valid_q && bus.id_ready;

    fetch_pc_gen #(.WIDTH(WIDTH)) u_pc_gen (
        .pc_q         (pc_q),
        .redirect     (redirect),
        .redirect_pc  (bus.redirect_pc),
        .accept       (accept),
        .instr        (bus.imem_data),
        .pc_d         (pc_d),
        .misaligned_d (misaligned_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (accept && bus.imem_data == EBREAK_INSN) state_d = HALT;
            HALT:    if (bus.start || bus.redirect_valid) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // IF/ID register: flush beats capture beats drain; otherwise hold (stall).
    always_comb begin
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if (redirect) begin
            if_valid_d = 1'b0;
        end else if (accept) begin
            if_valid_d = 1'b1;
            if_instr_d = bus.imem_data;
            if_pc_d    = pc_q;
        end else if (deliver) begin
            if_valid_d = 1'b0;
        end
    end

    assign fetch_count_d = fetch_count_q + {31'd0, deliver};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_addr   = pc_q[ADDR_W+1:2];
    assign bus.if_valid    = if_valid_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.misaligned  = misaligned_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Memory model: a 256-word array read combinationally at imem_addr.
module tb_fetch_unit;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [256];

    fetch_if #(.WIDTH(32), .ADDR_W(8)) bus ();

    fetch_unit #(.WIDTH(32), .SIZE(256), .ADDR_W(8), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h00A0_0093;
    localparam logic [31:0] JAL8   = 32'h0080_006F;
`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [31:0] JAL_NEXT = 32'h88;
`else
    localparam logic [31:0] JAL_NEXT = 32'h84;
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        mem[4]  = EBRK;   // 0x10
        mem[16] = ADDI;   // 0x40
        mem[32] = JAL8;   // 0x80

        reset = 1'b0;
        bus.start = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b1;

        // Reset values
        #3;
        chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_misaligned", {31'd0, bus.misaligned}, 32'd0);
        chk("rst_fetch_count", bus.fetch_count, 32'd0);
        chk("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
        tick();
        reset = 1'b1;

        // Start: RUN after one edge, first delivery after the next
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_no_valid_yet", {31'd0, bus.if_valid}, 32'd0);
        tick();
        chk("first_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("first_pc", bus.if_pc, 32'h0);
        chk("first_instr", bus.if_instr, NOP);
        tick();
        chk("seq_pc4", bus.if_pc, 32'h4);
        chk("seq_cnt1", bus.fetch_count, 32'd1);
        tick();
        chk("seq_pc8", bus.if_pc, 32'h8);

        // Stall three cycles on if_pc=8
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("stall_pc", bus.if_pc, 32'h8);
            chk("stall_instr", bus.if_instr, NOP);
            chk("stall_addr", {24'd0, bus.imem_addr}, 32'd3);
            chk("stall_cnt", bus.fetch_count, 32'd2);
        end
        bus.id_ready = 1'b1;
        tick();
        chk("resume_pc12", bus.if_pc, 32'hC);
        chk("resume_cnt3", bus.fetch_count, 32'd3);

        // EBREAK at 0x10: delivered, then HALT
        tick();
        chk("ebreak_pc", bus.if_pc, 32'h10);
        chk("ebreak_instr", bus.if_instr, EBRK);
        chk("ebreak_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("ebreak_halted", {31'd0, bus.halted}, 32'd1);
        chk("cnt4", bus.fetch_count, 32'd4);
        tick();
        chk("halt_drained", {31'd0, bus.if_valid}, 32'd0);
        chk("halt_cnt5", bus.fetch_count, 32'd5);
        tick();
        chk("halt_no_fetch", {31'd0, bus.if_valid}, 32'd0);
        chk("halt_still", {31'd0, bus.halted}, 32'd1);

        // Restart from HALT
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_halted0", {31'd0, bus.halted}, 32'd0);
        chk("restart_no_valid", {31'd0, bus.if_valid}, 32'd0);
        tick();
        chk("restart_pc14", bus.if_pc, 32'h14);
        tick();
        chk("restart_pc18", bus.if_pc, 32'h18);
        chk("restart_cnt6", bus.fetch_count, 32'd6);

        // Aligned redirect to 0x40 while if_valid=1
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir_flush", {31'd0, bus.if_valid}, 32'd0);
        chk("redir_addr", {24'd0, bus.imem_addr}, 32'd16);
        chk("redir_mis0", {31'd0, bus.misaligned}, 32'd0);
        chk("redir_cnt7", bus.fetch_count, 32'd7);
        tick();
        chk("redir_pc40", bus.if_pc, 32'h40);
        chk("redir_instr", bus.if_instr, ADDI);
        tick();
        chk("redir_pc44", bus.if_pc, 32'h44);

        // Misaligned redirect 0x42
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h42;
        tick();
        bus.redirect_valid = 1'b0;
        chk("mis_pulse", {31'd0, bus.misaligned}, 32'd1);
        chk("mis_flush", {31'd0, bus.if_valid}, 32'd0);
        tick();
        chk("mis_pulse_end", {31'd0, bus.misaligned}, 32'd0);
        chk("mis_pc40", bus.if_pc, 32'h40);
        chk("mis_cnt9", bus.fetch_count, 32'd9);

        // JAL at 0x80: next PC is +4 (or +8 when predicted)
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("jal_pc", bus.if_pc, 32'h80);
        chk("jal_instr", bus.if_instr, JAL8);
        tick();
        chk("jal_next_pc", bus.if_pc, JAL_NEXT);

        // PC wrap: 0xFFFF_FFFC + 4 -> 0
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wrap_addr_ff", {24'd0, bus.imem_addr}, 32'hFF);
        chk("wrap_cnt12", bus.fetch_count, 32'd12);
        tick();
        chk("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr0", {24'd0, bus.imem_addr}, 32'd0);

        // Async reset mid-stall, no clock edge needed
        bus.id_ready = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, bus.if_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("arst_cnt", bus.fetch_count, 32'd0);
        chk("arst_pc", bus.if_pc, 32'd0);
        chk("arst_halted", {31'd0, bus.halted}, 32'd0);

        // Redirect ignored in IDLE
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h43;
        tick();
        reset = 1'b1;
        tick();
        chk("idle_redir_addr", {24'd0, bus.imem_addr}, 32'd0);
        chk("idle_redir_mis", {31'd0, bus.misaligned}, 32'd0);
        chk("idle_redir_valid", {31'd0, bus.if_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("post_rst_pc", bus.if_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
